// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the ALU sequencing controller: FSM states,
// instruction class codes and the ALU function codes.
package alu_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_T1   = 3'd1,
        S_T2   = 3'd2,
        S_T3   = 3'd3,
        S_T4   = 3'd4
    } state_t;

    localparam logic [1:0] CLS_RR   = 2'b00;  // register-register ALU op
    localparam logic [1:0] CLS_MVI  = 2'b01;  // move immediate
    localparam logic [1:0] CLS_ADDI = 2'b10;  // add immediate
    localparam logic [1:0] CLS_SUBI = 2'b11;  // subtract immediate

    // Function codes understood by the ALU; anything outside FN_ADD..FN_SHR is illegal.
    localparam logic [3:0] FN_ADD  = 4'b0010;
    localparam logic [3:0] FN_SUB  = 4'b0011;
    localparam logic [3:0] FN_AND  = 4'b0100;
    localparam logic [3:0] FN_OR   = 4'b0101;
    localparam logic [3:0] FN_XOR  = 4'b0110;
    localparam logic [3:0] FN_NAND = 4'b0111;
    localparam logic [3:0] FN_NOR  = 4'b1000;
    localparam logic [3:0] FN_XNOR = 4'b1001;
    localparam logic [3:0] FN_SHL  = 4'b1010;
    localparam logic [3:0] FN_SHR  = 4'b1011;

    function automatic logic fn_is_legal(input logic [3:0] fn);
        return (fn >= FN_ADD) && (fn <= FN_SHR);
    endfunction

endpackage

// File: rtl/instr_decode.sv
// Combinational split of the latched instruction word into its fields.
// The immediate is not needed here: the datapath routes it when EXTERN is high.
module instr_decode
    import alu_ctrl_pkg::*;
(
    input  logic [9:0] ir,
    output logic [1:0] cls,
    output logic [3:0] fn,
    output logic [1:0] rx,
    output logic [1:0] ry,
    output logic       legal
);

    always_comb begin
        cls   = ir[9:8];
        fn    = ir[7:4];
        ry    = ir[1:0];
        // Rx sits at [3:2] for reg-reg and at [7:6] for the immediate classes.
        rx    = (ir[9:8] == CLS_RR) ? ir[3:2] : ir[7:6];
        legal = (ir[9:8] != CLS_RR) || fn_is_legal(ir[7:4]);
    end

endmodule

// File: rtl/alu_seq_ctrl.sv
// Multi-cycle ALU sequencer: latches an instruction on START and steps
// T1..T4 driving Moore-style register/ALU strobes from state and IR.
module alu_seq_ctrl
    import alu_ctrl_pkg::*;
#(
    parameter int N    = 10,
    parameter int NREG = 4
) (
    input  logic            CLKb,
    input  logic            RSTb,
    input  logic            START,
    input  logic [N-1:0]    INSTR,
    output logic            BUSY,
    output logic            DONE,
    output logic            ERR,
    output logic            Ain,
    output logic            Gin,
    output logic            Gout,
    output logic [3:0]      FN,
    output logic [1:0]      OPCLS,
    output logic [NREG-1:0] ROUT,
    output logic [NREG-1:0] RIN,
    output logic            EXTERN
);

    state_t         state_reg, state_next;
    logic [N-1:0]   ir_reg, ir_next;

    logic [1:0]     dec_cls;
    logic [3:0]     dec_fn;
    logic [1:0]     dec_rx;
    logic [1:0]     dec_ry;
    logic           dec_legal;

    logic           rout_en;
    logic [1:0]     rout_idx;
    logic           rin_en;

    instr_decode u_decode (
        .ir    (ir_reg[9:0]),
        .cls   (dec_cls),
        .fn    (dec_fn),
        .rx    (dec_rx),
        .ry    (dec_ry),
        .legal (dec_legal)
    );

    always_ff @(posedge CLKb) begin
        if (!RSTb) begin
            state_reg <= S_IDLE;
            ir_reg    <= '0;
        end else begin
            state_reg <= state_next;
            ir_reg    <= ir_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        ir_next    = ir_reg;
        case (state_reg)
            S_IDLE: begin
                if (START) begin
                    state_next = S_T1;
                    ir_next    = INSTR;
                end
            end
            S_T1: begin
                if (dec_cls == CLS_MVI || !dec_legal)
                    state_next = S_IDLE;
                else
                    state_next = S_T2;
            end
            S_T2:    state_next = S_T3;
            S_T3:    state_next = S_T4;
            S_T4:    state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        BUSY     = (state_reg != S_IDLE);
        DONE     = 1'b0;
        ERR      = 1'b0;
        Ain      = 1'b0;
        Gin      = 1'b0;
        Gout     = 1'b0;
        EXTERN   = 1'b0;
        FN       = 4'b0000;
        OPCLS    = 2'b00;
        rout_en  = 1'b0;
        rout_idx = dec_rx;
        rin_en   = 1'b0;
        if (state_reg != S_IDLE) begin
            FN    = dec_fn;
            OPCLS = dec_cls;
        end
        case (state_reg)
            S_T1: begin
                if (!dec_legal) begin
                    ERR = 1'b1;
                end else if (dec_cls == CLS_MVI) begin
                    EXTERN = 1'b1;
                    rin_en = 1'b1;
                    DONE   = 1'b1;
                end else begin
                    rout_en = 1'b1;
                    Ain     = 1'b1;
                end
            end
            S_T2: begin
                Gin = 1'b1;
                if (dec_cls == CLS_RR) begin
                    rout_en  = 1'b1;
                    rout_idx = dec_ry;
                end else begin
                    EXTERN = 1'b1;
                end
            end
            // Gout spans T3 and T4 so the falling-edge ALU capture stays valid for write-back.
            S_T3: Gout = 1'b1;
            S_T4: begin
                Gout   = 1'b1;
                rin_en = 1'b1;
                DONE   = 1'b1;
            end
            default: ;
        endcase
    end

    // Both selects come from a single index, so each is one-hot or zero by construction.
    generate
        for (genvar gi = 0; gi < NREG; gi++) begin : g_sel
            assign ROUT[gi] = rout_en && (int'(rout_idx) == gi);
            assign RIN[gi]  = rin_en  && (int'(dec_rx) == gi);
        end
    endgenerate

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed bench for alu_seq_ctrl: per-cycle checks of the packed output
// vector against hand-computed expectations.
module tb_alu_seq_ctrl;

    logic       CLKb = 1'b0;
    logic       RSTb = 1'b0;
    logic       START = 1'b0;
    logic [9:0] INSTR = '0;
    logic       BUSY, DONE, ERR, Ain, Gin, Gout, EXTERN;
    logic [3:0] FN, ROUT, RIN;
    logic [1:0] OPCLS;

    int errors = 0;
    int checks = 0;

    alu_seq_ctrl #(.N(10), .NREG(4)) dut (
        .CLKb   (CLKb),
        .RSTb   (RSTb),
        .START  (START),
        .INSTR  (INSTR),
        .BUSY   (BUSY),
        .DONE   (DONE),
        .ERR    (ERR),
        .Ain    (Ain),
        .Gin    (Gin),
        .Gout   (Gout),
        .FN     (FN),
        .OPCLS  (OPCLS),
        .ROUT   (ROUT),
        .RIN    (RIN),
        .EXTERN (EXTERN)
    );

    always #5 CLKb = ~CLKb;

    // Packed as {BUSY,DONE,ERR,Ain,Gin,Gout,EXTERN,ROUT,RIN,OPCLS,FN}.
    logic [20:0] obs;
    assign obs = {BUSY, DONE, ERR, Ain, Gin, Gout, EXTERN, ROUT, RIN, OPCLS, FN};

    function automatic logic [20:0] mk(input logic busy, done, err, ain, gin, gout, ext,
                                       input logic [3:0] rout, rin,
                                       input logic [1:0] opcls,
                                       input logic [3:0] fn);
        return {busy, done, err, ain, gin, gout, ext, rout, rin, opcls, fn};
    endfunction

    localparam logic [20:0] IDLE_OUT = 21'h0;

    task automatic check(input string tag, input logic [20:0] got, input logic [20:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %06h expected %06h (busy,done,err,ain,gin,gout,ext,rout,rin,opcls,fn)",
                     tag, got, exp);
        end else begin
            $display("ok   %s: %06h", tag, got);
        end
    endtask

    task automatic cyc;
        @(negedge CLKb);
    endtask

    logic [9:0]  hold_instr [13];
    logic [20:0] hold_exp   [13];

    initial begin
        // Reset with START high: reset must win.
        RSTb = 1'b0; START = 1'b1; INSTR = 10'b00_0010_01_10;
        cyc; cyc;
        check("reset", obs, IDLE_OUT);

        // ADD R1,R2
        RSTb = 1'b1;
        cyc; START = 1'b0;
        check("add_t1", obs, mk(1,0,0,1,0,0,0, 4'b0010, 4'b0000, 2'b00, 4'b0010));
        cyc; check("add_t2", obs, mk(1,0,0,0,1,0,0, 4'b0100, 4'b0000, 2'b00, 4'b0010));
        cyc; check("add_t3", obs, mk(1,0,0,0,0,1,0, 4'b0000, 4'b0000, 2'b00, 4'b0010));
        cyc; check("add_t4", obs, mk(1,1,0,0,0,1,0, 4'b0000, 4'b0010, 2'b00, 4'b0010));
        cyc; check("add_idle", obs, IDLE_OUT);

        // ADDI R1,5
        START = 1'b1; INSTR = 10'b10_01_000101;
        cyc; START = 1'b0;
        check("addi_t1", obs, mk(1,0,0,1,0,0,0, 4'b0010, 4'b0000, 2'b10, 4'b0100));
        cyc; check("addi_t2", obs, mk(1,0,0,0,1,0,1, 4'b0000, 4'b0000, 2'b10, 4'b0100));
        cyc; check("addi_t3", obs, mk(1,0,0,0,0,1,0, 4'b0000, 4'b0000, 2'b10, 4'b0100));
        cyc; check("addi_t4", obs, mk(1,1,0,0,0,1,0, 4'b0000, 4'b0010, 2'b10, 4'b0100));
        cyc; check("addi_idle", obs, IDLE_OUT);

        // MVI R3,42: single busy cycle
        START = 1'b1; INSTR = 10'b01_11_101010;
        cyc; START = 1'b0;
        check("mvi_t1", obs, mk(1,1,0,0,0,0,1, 4'b0000, 4'b1000, 2'b01, 4'b1110));
        cyc; check("mvi_idle", obs, IDLE_OUT);

        // Illegal FN=1111
        START = 1'b1; INSTR = 10'b00_1111_00_00;
        cyc; START = 1'b0;
        check("ill_hi_t1", obs, mk(1,0,1,0,0,0,0, 4'b0000, 4'b0000, 2'b00, 4'b1111));
        cyc; check("ill_hi_idle", obs, IDLE_OUT);

        // Illegal FN=0001, just below the legal range
        START = 1'b1; INSTR = 10'b00_0001_00_00;
        cyc; START = 1'b0;
        check("ill_lo_t1", obs, mk(1,0,1,0,0,0,0, 4'b0000, 4'b0000, 2'b00, 4'b0001));
        cyc; check("ill_lo_idle", obs, IDLE_OUT);

        // FN=1011 (top of legal range) with Rx=Ry=3
        START = 1'b1; INSTR = 10'b00_1011_11_11;
        cyc; START = 1'b0;
        check("rxry_t1", obs, mk(1,0,0,1,0,0,0, 4'b1000, 4'b0000, 2'b00, 4'b1011));
        cyc; check("rxry_t2", obs, mk(1,0,0,0,1,0,0, 4'b1000, 4'b0000, 2'b00, 4'b1011));
        cyc; check("rxry_t3", obs, mk(1,0,0,0,0,1,0, 4'b0000, 4'b0000, 2'b00, 4'b1011));
        cyc; check("rxry_t4", obs, mk(1,1,0,0,0,1,0, 4'b0000, 4'b1000, 2'b00, 4'b1011));
        cyc; check("rxry_idle", obs, IDLE_OUT);

        // START held for 10 cycles with INSTR changing every cycle
        hold_instr[0]  = 10'b00_0011_00_11;  // SUB R0,R3 accepted
        hold_instr[1]  = 10'b01_01_111111;
        hold_instr[2]  = 10'b00_0100_10_01;
        hold_instr[3]  = 10'b01_11_000000;
        hold_instr[4]  = 10'b10_00_000001;
        hold_instr[5]  = 10'b01_10_000001;  // MVI R2 accepted in first idle cycle
        hold_instr[6]  = 10'b01_00_000000;
        hold_instr[7]  = 10'b00_0000_00_00;  // illegal, accepted
        hold_instr[8]  = 10'b11_01_010101;
        hold_instr[9]  = 10'b11_10_000011;  // SUBI R2,3 accepted
        hold_instr[10] = 10'b01_01_000000;
        hold_instr[11] = 10'b01_01_000000;
        hold_instr[12] = 10'b01_01_000000;
        hold_exp[0]  = mk(1,0,0,1,0,0,0, 4'b0001, 4'b0000, 2'b00, 4'b0011);
        hold_exp[1]  = mk(1,0,0,0,1,0,0, 4'b1000, 4'b0000, 2'b00, 4'b0011);
        hold_exp[2]  = mk(1,0,0,0,0,1,0, 4'b0000, 4'b0000, 2'b00, 4'b0011);
        hold_exp[3]  = mk(1,1,0,0,0,1,0, 4'b0000, 4'b0001, 2'b00, 4'b0011);
        hold_exp[4]  = IDLE_OUT;
        hold_exp[5]  = mk(1,1,0,0,0,0,1, 4'b0000, 4'b0100, 2'b01, 4'b1000);
        hold_exp[6]  = IDLE_OUT;
        hold_exp[7]  = mk(1,0,1,0,0,0,0, 4'b0000, 4'b0000, 2'b00, 4'b0000);
        hold_exp[8]  = IDLE_OUT;
        hold_exp[9]  = mk(1,0,0,1,0,0,0, 4'b0100, 4'b0000, 2'b11, 4'b1000);
        hold_exp[10] = mk(1,0,0,0,1,0,1, 4'b0000, 4'b0000, 2'b11, 4'b1000);
        hold_exp[11] = mk(1,0,0,0,0,1,0, 4'b0000, 4'b0000, 2'b11, 4'b1000);
        hold_exp[12] = mk(1,1,0,0,0,1,0, 4'b0000, 4'b0100, 2'b11, 4'b1000);
        START = 1'b1; INSTR = hold_instr[0];
        for (int k = 0; k < 13; k++) begin
            cyc;
            check($sformatf("hold_c%0d", k), obs, hold_exp[k]);
            if (k == 9) START = 1'b0;
            if (k < 12) INSTR = hold_instr[k+1];
        end
        cyc; check("hold_idle", obs, IDLE_OUT);

        // Reset during T3 of an ADD aborts it
        START = 1'b1; INSTR = 10'b00_0010_01_10;
        cyc; START = 1'b0;
        check("abort_t1", obs, mk(1,0,0,1,0,0,0, 4'b0010, 4'b0000, 2'b00, 4'b0010));
        cyc; cyc;
        check("abort_t3", obs, mk(1,0,0,0,0,1,0, 4'b0000, 4'b0000, 2'b00, 4'b0010));
        RSTb = 1'b0;
        cyc; RSTb = 1'b1;
        check("abort_rst", obs, IDLE_OUT);
        for (int k = 0; k < 3; k++) begin
            cyc;
            check($sformatf("abort_after%0d", k), obs, IDLE_OUT);
        end
        START = 1'b1; INSTR = 10'b00_0010_01_10;
        cyc; START = 1'b0;
        check("restart_t1", obs, mk(1,0,0,1,0,0,0, 4'b0010, 4'b0000, 2'b00, 4'b0010));
        cyc; cyc; cyc;
        check("restart_t4", obs, mk(1,1,0,0,0,1,0, 4'b0000, 4'b0010, 2'b00, 4'b0010));
        cyc; check("restart_idle", obs, IDLE_OUT);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
